// File: rtl/dial_cmd_arbiter.sv
// dial_cmd_arbiter: two-requester round-robin arbiter offering dial commands to a core.
// Define ARB_STATS_EN to add saturating per-requester issued-command counters.
module dial_cmd_arbiter #(
    parameter int DIST_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_direction,
    input  logic [DIST_W-1:0] req0_distance,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_direction,
    input  logic [DIST_W-1:0] req1_distance,
    output logic              core_valid,
    input  logic              core_ready,
    output logic              core_direction,
    output logic [DIST_W-1:0] core_distance,
    output logic              grant_id,
    output logic              busy
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]       issued0_count,
    output logic [15:0]       issued1_count
`endif
);
    typedef enum logic {IDLE, ISSUE} state_t;
    state_t state_q, state_d;
    logic [1:0] slot_full_q, slot_full_d, slot_dir_q, slot_dir_d;
    logic [1:0][DIST_W-1:0] slot_dist_q, slot_dist_d;
    logic core_valid_q, core_valid_d, core_dir_q, core_dir_d;
    logic grant_q, grant_d, last_grant_q, last_grant_d;
    logic [DIST_W-1:0] core_dist_q, core_dist_d;
    logic [1:0] req_valid, req_dir;
    logic [1:0][DIST_W-1:0] req_dist;
    logic grant_sel, handshake;

    assign req_valid = {req1_valid, req0_valid};
    assign req_dir   = {req1_direction, req0_direction};
    assign req_dist  = {req1_distance, req0_distance};
    // On a tie the slot that did not win last time is served.
    assign grant_sel = &slot_full_q ? ~last_grant_q : slot_full_q[1];
    assign handshake = core_valid_q && core_ready;

    always_comb begin
        state_d      = state_q;
        slot_full_d  = slot_full_q;
        slot_dir_d   = slot_dir_q;
        slot_dist_d  = slot_dist_q;
        core_valid_d = core_valid_q;
        core_dir_d   = core_dir_q;
        core_dist_d  = core_dist_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        if (state_q == IDLE && |slot_full_q) begin
            state_d                = ISSUE;
            core_valid_d           = 1'b1;
            core_dir_d             = slot_dir_q[grant_sel];
            core_dist_d            = slot_dist_q[grant_sel];
            grant_d                = grant_sel;
            last_grant_d           = grant_sel;
            slot_full_d[grant_sel] = 1'b0;
        end else if (state_q == ISSUE && handshake) begin
            state_d      = IDLE;
            core_valid_d = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            if (req_valid[i] && !slot_full_q[i]) begin
                slot_full_d[i] = 1'b1;
                slot_dir_d[i]  = req_dir[i];
                slot_dist_d[i] = req_dist[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            slot_full_q  <= '0;
            slot_dir_q   <= '0;
            slot_dist_q  <= '0;
            core_valid_q <= 1'b0;
            core_dir_q   <= 1'b0;
            core_dist_q  <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            slot_full_q  <= slot_full_d;
            slot_dir_q   <= slot_dir_d;
            slot_dist_q  <= slot_dist_d;
            core_valid_q <= core_valid_d;
            core_dir_q   <= core_dir_d;
            core_dist_q  <= core_dist_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign req0_ready     = ~slot_full_q[0];
    assign req1_ready     = ~slot_full_q[1];
    assign core_valid     = core_valid_q;
    assign core_direction = core_dir_q;
    assign core_distance  = core_dist_q;
    assign grant_id       = grant_q;
    assign busy           = |slot_full_q || core_valid_q;

`ifdef ARB_STATS_EN
    logic [1:0][15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (handshake && cnt_q[grant_q] != 16'hFFFF)
            cnt_d[grant_q] = cnt_q[grant_q] + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end

    assign issued0_count = cnt_q[0];
    assign issued1_count = cnt_q[1];
`endif
endmodule

// File: tb/tb_dial_cmd_arbiter.sv
// tb_dial_cmd_arbiter: directed and randomized checks of dial_cmd_arbiter against a reference model.
module tb_dial_cmd_arbiter;
    localparam int W = 16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req0_valid = 0, req0_direction = 0, req1_valid = 0, req1_direction = 0, core_ready = 0;
    logic [W-1:0] req0_distance = '0, req1_distance = '0;
    logic req0_ready, req1_ready, core_valid, core_direction, grant_id, busy;
    logic [W-1:0] core_distance;
`ifdef ARB_STATS_EN
    logic [15:0] issued0_count, issued1_count;
`endif

    always #5 clk = ~clk;

    dial_cmd_arbiter #(.DIST_W(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_direction(req0_direction), .req0_distance(req0_distance),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_direction(req1_direction), .req1_distance(req1_distance),
        .core_valid(core_valid), .core_ready(core_ready),
        .core_direction(core_direction), .core_distance(core_distance),
        .grant_id(grant_id), .busy(busy)
`ifdef ARB_STATS_EN
        , .issued0_count(issued0_count), .issued1_count(issued1_count)
`endif
    );

    int n_chk = 0, n_fail = 0;
    bit chk_en = 0;
    bit acc0, acc1, sr0, sr1;
    bit glog[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: two holding slots, one offer register, round-robin memory.
    bit m_full[2], m_dir[2], m_cv, m_cdir, m_gid, m_last;
    logic [W-1:0] m_dist[2], m_cdist;
    int m_cnt[2];

    always @(posedge clk) begin : model
        bit a0, a1;
        int g;
        if (rst) begin
            m_full = '{0, 0}; m_cv = 0; m_cdir = 0; m_cdist = '0;
            m_gid = 0; m_last = 1; m_cnt = '{0, 0};
        end else begin
            a0 = req0_valid && !m_full[0];
            a1 = req1_valid && !m_full[1];
            if (!m_cv) begin
                if (m_full[0] || m_full[1]) begin
                    g = (m_full[0] && m_full[1]) ? int'(!m_last) : (m_full[0] ? 0 : 1);
                    m_cv = 1; m_cdir = m_dir[g]; m_cdist = m_dist[g];
                    m_gid = g[0]; m_last = g[0]; m_full[g] = 0;
                end
            end else if (core_ready) begin
                m_cv = 0;
                if (m_cnt[m_gid] < 65535) m_cnt[m_gid]++;
            end
            if (a0) begin m_full[0] = 1; m_dir[0] = req0_direction; m_dist[0] = req0_distance; end
            if (a1) begin m_full[1] = 1; m_dir[1] = req1_direction; m_dist[1] = req1_distance; end
        end
    end

    always @(negedge clk) begin
        sr0 = req0_ready;
        sr1 = req1_ready;
        if (chk_en) begin
            if (!rst && core_valid && core_ready) glog.push_back(grant_id);
            check("core_valid", core_valid, m_cv);
            check("core_direction", core_direction, m_cdir);
            check("core_distance", core_distance, m_cdist);
            check("grant_id", grant_id, m_gid);
            check("req0_ready", req0_ready, !m_full[0]);
            check("req1_ready", req1_ready, !m_full[1]);
            check("busy", busy, m_full[0] || m_full[1] || m_cv);
`ifdef ARB_STATS_EN
            check("issued0_count", issued0_count, m_cnt[0]);
            check("issued1_count", issued1_count, m_cnt[1]);
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        acc0 = req0_valid && sr0 && !rst;
        acc1 = req1_valid && sr1 && !rst;
        #1;
    endtask

    task automatic do_reset();
        req0_valid = 0; req1_valid = 0; rst = 1;
        cyc();
        rst = 0;
    endtask

    function automatic logic [W-1:0] rand_dist();
        int k = $urandom_range(0, 3);
        return k == 0 ? '0 : k == 1 ? '1 : W'($urandom);
    endfunction

`ifdef ARB_STATS_EN
    task automatic send(input bit r, input bit d, input logic [W-1:0] dist);
        bit done = 0;
        if (r) begin req1_valid = 1; req1_direction = d; req1_distance = dist; end
        else begin req0_valid = 1; req0_direction = d; req0_distance = dist; end
        for (int i = 0; i < 20 && !done; i++) begin
            cyc();
            done = r ? acc1 : acc0;
        end
        req0_valid = 0; req1_valid = 0;
        check("send_accepted", done, 1);
        for (int i = 0; i < 3; i++) cyc();
    endtask
`endif

    initial begin
        int rem0, rem1, guard;
        cyc();
        chk_en = 1;
        cyc();
        rst = 0;
        @(negedge clk);
        check("rst_core_valid", core_valid, 0);
        check("rst_ready0", req0_ready, 1);
        check("rst_ready1", req1_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_grant", grant_id, 0);
        check("rst_distance", core_distance, 0);

        // single R50 with an always-ready core
        core_ready = 1;
        req0_valid = 1; req0_direction = 1; req0_distance = 50;
        cyc();
        req0_valid = 0;
        cyc();
        @(negedge clk);
        check("r50_valid", core_valid, 1);
        check("r50_dir", core_direction, 1);
        check("r50_dist", core_distance, 50);
        check("r50_grant", grant_id, 0);
        cyc();
        @(negedge clk);
        check("r50_pulse", core_valid, 0);

        // simultaneous arrival after reset: requester 0 wins the first tie
        do_reset();
        req0_valid = 1; req0_direction = 0; req0_distance = 68;
        req1_valid = 1; req1_direction = 1; req1_distance = 30;
        cyc();
        req0_valid = 0; req1_valid = 0;
        cyc();
        @(negedge clk);
        check("tie_first_grant", grant_id, 0);
        check("tie_first_dist", core_distance, 68);
        check("tie_first_dir", core_direction, 0);
        cyc();
        @(negedge clk);
        check("tie_gap", core_valid, 0);
        cyc();
        @(negedge clk);
        check("tie_second_grant", grant_id, 1);
        check("tie_second_dist", core_distance, 30);
        check("tie_second_dir", core_direction, 1);
        cyc();

        // stalled core with the slot refilled behind the offer
        do_reset();
        core_ready = 0;
        req0_valid = 1; req0_direction = 1; req0_distance = 1000;
        cyc();
        req0_direction = 0; req0_distance = 7;
        cyc();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", core_valid, 1);
            check("stall_dist", core_distance, 1000);
            check("stall_dir", core_direction, 1);
            cyc();
            if (acc0) req0_valid = 0;
        end
        @(negedge clk);
        check("stall_refilled", req0_ready, 0);
        core_ready = 1;
        cyc();
        @(negedge clk);
        check("stall_release", core_valid, 0);
        cyc();
        @(negedge clk);
        check("refill_dist", core_distance, 7);
        check("refill_dir", core_direction, 0);
        cyc();

        // reset while offering with both slots full
        do_reset();
        core_ready = 0;
        req0_valid = 1; req0_direction = 1; req0_distance = 5;
        req1_valid = 1; req1_direction = 0; req1_distance = 6;
        cyc();
        req1_valid = 0; req0_distance = 9;
        cyc();
        cyc();
        req0_valid = 0;
        @(negedge clk);
        check("full_busy", busy, 1);
        check("full_ready0", req0_ready, 0);
        check("full_ready1", req1_ready, 0);
        rst = 1;
        cyc();
        rst = 0;
        @(negedge clk);
        check("midrst_valid", core_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready0", req0_ready, 1);
        check("midrst_ready1", req1_ready, 1);
        core_ready = 1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            @(negedge clk);
            check("no_stale_offer", core_valid, 0);
        end

        // both requesters streaming six commands each
        do_reset();
        glog.delete();
        core_ready = 1;
        rem0 = 6; rem1 = 6;
        req0_valid = 1; req0_distance = rand_dist();
        req1_valid = 1; req1_distance = rand_dist();
        guard = 0;
        while ((rem0 > 0 || rem1 > 0 || busy) && guard < 200) begin
            cyc();
            guard++;
            if (acc0) begin rem0--; req0_valid = rem0 > 0; req0_distance = rand_dist(); req0_direction = 1'($urandom); end
            if (acc1) begin rem1--; req1_valid = rem1 > 0; req1_distance = rand_dist(); req1_direction = 1'($urandom); end
        end
        check("stream_timeout", guard < 200, 1);
        @(negedge clk);
        check("stream_count", glog.size(), 12);
        if (glog.size() > 0) check("stream_first", glog[0], 0);
        for (int i = 1; i < glog.size(); i++) check("stream_alternate", glog[i], !glog[i-1]);

`ifdef ARB_STATS_EN
        do_reset();
        core_ready = 1;
        send(0, 1, 11); send(0, 0, 12); send(1, 1, 13); send(0, 1, 14); send(1, 0, 15);
        @(negedge clk);
        check("stats0", issued0_count, 3);
        check("stats1", issued1_count, 2);
`endif

        // randomized traffic, stalls and occasional resets
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            core_ready = $urandom_range(0, 3) != 0;
            rst = $urandom_range(0, 199) == 0;
            if (!req0_valid && $urandom_range(0, 1) == 1) begin
                req0_valid = 1; req0_direction = 1'($urandom); req0_distance = rand_dist();
            end
            if (!req1_valid && $urandom_range(0, 1) == 1) begin
                req1_valid = 1; req1_direction = 1'($urandom); req1_distance = rand_dist();
            end
            cyc();
            if (acc0) req0_valid = 0;
            if (acc1) req1_valid = 0;
        end
        rst = 0;
        cyc();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dial_cmd_arbiter.md
DIAL_CMD_ARBITER -- requirements
Module: dial_cmd_arbiter

Interface
REQ-001 SHALL have parameter: DIST_W, default 16, width of all distance fields.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports: req0_valid / req1_valid  input  1  requester command present.
REQ-005 SHALL have ports: req0_ready / req1_ready  output  1  requester holding slot empty.
REQ-006 SHALL have ports: req0_direction / req1_direction  input  1  1 = R (clockwise), 0 = L.
REQ-007 SHALL have ports: req0_distance / req1_distance  input  DIST_W  rotation amount in clicks.
REQ-008 SHALL have port: core_valid  output  1  command offered to dial core.
REQ-009 SHALL have port: core_ready  input  1  dial core can accept a command.
REQ-010 SHALL have ports: core_direction  output  1, core_distance  output  DIST_W  offered command fields.
REQ-011 SHALL have port: grant_id  output  1  requester index of the command currently or last offered.
REQ-012 SHALL have port: busy  output  1  high when any holding slot is full or core_valid is high.

Function
REQ-013 SHALL accept a requester command on a rising edge where reqN_valid && reqN_ready, capturing direction and distance into holding slot N.
REQ-014 SHALL drive reqN_ready = NOT slotN_full, registered; no combinational path from core_ready to reqN_ready.
REQ-015 SHALL implement FSM states IDLE and ISSUE; IDLE -> ISSUE on an edge where either slot is full; ISSUE -> IDLE on an edge where core_valid && core_ready.
REQ-016 SHALL, on the IDLE -> ISSUE edge, load the granted slot into core_direction/core_distance, set core_valid, set grant_id, and clear that slot.
REQ-017 SHALL grant round-robin: only one slot full -> that slot; both full -> the slot not equal to last_grant.
REQ-018 SHALL hold core_valid, core_direction, core_distance and grant_id stable while core_valid && !core_ready.
REQ-019 SHALL deassert core_valid on the edge following a core handshake, so that there is at least one idle cycle between consecutive offers.
REQ-020 SHALL produce latency: command accepted at edge E -> core_valid high after edge E+1 when FSM is IDLE at E+1.
REQ-021 SHALL allow a slot cleared on edge E to accept a new command on edge E+1 while the FSM is still in ISSUE.
REQ-022 SHALL forward distance 0 and DIST_W all-ones unchanged; no modulo or saturation in this block.
REQ-023 SHALL ignore reqN_valid while slotN is full; the requester must hold its command until reqN_ready is high.

Reset
REQ-024 SHALL on rst set: FSM IDLE, both slots empty, req0_ready = req1_ready = 1 on the following cycle, core_valid 0, core_direction 0, core_distance 0, grant_id 0, busy 0.
REQ-025 SHALL on rst set last_grant = 1, so that requester 0 wins the first tie.
REQ-026 SHALL discard pending slot contents and any offered command on reset asserted mid-operation, and no handshake is counted in the reset cycle.
REQ-027 SHALL give rst priority over all other events in the same cycle.

Configuration
REQ-028 SHALL, with ARB_STATS_EN defined, add outputs issued0_count and issued1_count, each 16 bits, incremented on each core handshake whose grant_id matches, saturating at 16'hFFFF and reset to 0.
REQ-029 SHALL, without ARB_STATS_EN, omit those ports and counters; all other behaviour SHALL be identical.

Verification
REQ-030 SHALL pass: a single req0 R50 with core_ready=1 -> core_valid high one cycle after accept, core_direction=1, core_distance=50, grant_id=0, one-cycle pulse.
REQ-031 SHALL pass: req0 L68 and req1 R30 accepted on the same edge after reset -> req0 offered first, then req1; grant_id sequence 0,1.
REQ-032 SHALL pass: both requesters streaming continuously for 6 commands each -> grants strictly alternate 0,1,0,1,... with no starvation.
REQ-033 SHALL pass: core_ready held low 5 cycles during an offer of R1000 -> outputs stable for 5 cycles; one handshake; req0 slot refilled meanwhile.
REQ-034 SHALL pass: rst asserted while in ISSUE with both slots full -> next cycle core_valid=0, busy=0, both readys=1, and no stale command is later offered.
REQ-035 SHALL pass, with ARB_STATS_EN: 3 req0 and 2 req1 commands -> issued0_count=3, issued1_count=2; with counters preloaded near 16'hFFFF they hold at 16'hFFFF.
